// File: rtl/aes_serial_host.sv
// ---------------------------------------------------------------------------
// aes_serial_host
//
// Host-side initiator for the bit-serial AES core interface. It accepts a
// 128-bit block and a key in parallel and shifts them into the core LSB-first
// while cs is high. It then drops cs and waits for the core's finished flag,
// raises cs again and shifts the 128-bit result back into data_out.
//
// Parameters:
//   NK       key length in 32-bit words (4, 6 or 8); KEY_W = 32*NK
//   TIMEOUT  maximum number of WAIT cycles when the watchdog is built in
//
// Ports:
//   clk       sole clock, rising edge
//   rst       synchronous, active-low reset
//   start     request pulse, accepted only while idle
//   data_in   128-bit block, captured on an accepted start
//   key_in    KEY_W-bit key, captured on an accepted start
//   busy      high whenever the host is not idle
//   done      one-cycle pulse when data_out is updated
//   err       one-cycle pulse on a watchdog abort (always 0 without it)
//   data_out  last received result, held until the next done
//   cs        chip select to the core
//   miso      serial data to the core
//   mosi      serial data from the core
//   finished  core completion flag
//
// Optional feature: define AES_HOST_TIMEOUT_EN to build the WAIT watchdog.
// ---------------------------------------------------------------------------
module aes_serial_host #(
   parameter int NK      = 8,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [127:0]      data_in,
   input  logic [32*NK-1:0]  key_in,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [127:0]      data_out,
   output logic              cs,
   output logic              miso,
   input  logic              mosi,
   input  logic              finished
);

   localparam int KEY_W   = 32 * NK;
   localparam int SHIFT_W = 128 + KEY_W;

   // Last bit index for each serial phase, sized to the 9-bit bit counter.
   localparam logic [8:0] LOAD_LAST = 9'(SHIFT_W - 1);
   localparam logic [8:0] READ_LAST = 9'd127;

   // Reject parameter values the serial protocol and 8-bit watchdog cannot handle.
   if (NK != 4 && NK != 6 && NK != 8) begin : gBadNk
      $error("aes_serial_host: NK must be 4, 6 or 8");
   end
   if (TIMEOUT < 1 || TIMEOUT > 256) begin : gBadTimeout
      $error("aes_serial_host: TIMEOUT must be in 1..256");
   end

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      LOAD,
      WAIT,
      TURN,
      READ
   } stateT;

   stateT              state;
   logic [SHIFT_W-1:0] shiftReg;
   logic [8:0]         bitCount;
   logic [126:0]       result;

`ifdef AES_HOST_TIMEOUT_EN
   logic [7:0]         watchdog;
`else
   assign err = 1'b0;
`endif

   // Single sequencer: every output is a register updated here.
   // The transmit register shifts right so its bit 0 is always the next bit
   // on miso; the receive register shifts right with mosi entering at the top,
   // so after 127 shifts plus the final mosi bit the first bit lands at bit 0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         shiftReg <= '0;
         bitCount <= '0;
         result   <= '0;
         data_out <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         cs       <= 1'b0;
         miso     <= 1'b0;
`ifdef AES_HOST_TIMEOUT_EN
         err      <= 1'b0;
         watchdog <= '0;
`endif
      end else begin
         done <= 1'b0;
`ifdef AES_HOST_TIMEOUT_EN
         err  <= 1'b0;
`endif
         case (state)
            IDLE: begin
               cs   <= 1'b0;
               miso <= 1'b0;
               if (start) begin
                  shiftReg <= {key_in, data_in};
                  bitCount <= '0;
                  state    <= SETUP;
                  busy     <= 1'b1;
                  cs       <= 1'b1;
               end
            end

            SETUP: begin
               miso     <= shiftReg[0];
               shiftReg <= shiftReg >> 1;
               bitCount <= '0;
               state    <= LOAD;
            end

            LOAD: begin
               if (bitCount == LOAD_LAST) begin
                  cs    <= 1'b0;
                  miso  <= 1'b0;
                  state <= WAIT;
`ifdef AES_HOST_TIMEOUT_EN
                  watchdog <= '0;
`endif
               end else begin
                  miso     <= shiftReg[0];
                  shiftReg <= shiftReg >> 1;
                  bitCount <= bitCount + 9'd1;
               end
            end

            WAIT: begin
               if (finished) begin
                  cs    <= 1'b1;
                  state <= TURN;
               end
`ifdef AES_HOST_TIMEOUT_EN
               else if (watchdog == 8'(TIMEOUT - 1)) begin
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  watchdog <= watchdog + 8'd1;
               end
`endif
            end

            TURN: begin
               bitCount <= '0;
               state    <= READ;
            end

            READ: begin
               result <= {mosi, result[126:1]};
               if (bitCount == READ_LAST) begin
                  data_out <= {mosi, result};
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  cs       <= 1'b0;
                  state    <= IDLE;
               end else begin
                  bitCount <= bitCount + 9'd1;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               cs    <= 1'b0;
               miso  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_serial_host.sv
// ---------------------------------------------------------------------------
// tb_aes_serial_host
//
// Testbench for aes_serial_host. Two hosts (NK=8 and NK=4) share reset, mosi
// and finished; only one is active at a time and a behavioural core model
// serves whichever is selected. The core checks the serial load stream and
// returns a fixed result; a monitor compares data_out against a queue of
// expected results on every done pulse.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aes_serial_host;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          mosi;
   logic          finished;
   logic          sel;

   logic          start8, start4;
   logic [127:0]  dataIn8, dataIn4;
   logic [255:0]  keyIn8;
   logic [127:0]  keyIn4;
   logic          busy8, done8, err8, cs8, miso8;
   logic          busy4, done4, err4, cs4, miso4;
   logic [127:0]  dataOut8, dataOut4;

   aes_serial_host #(.NK(8), .TIMEOUT(64)) u8 (
      .clk(clk), .rst(rst), .start(start8), .data_in(dataIn8), .key_in(keyIn8),
      .busy(busy8), .done(done8), .err(err8), .data_out(dataOut8),
      .cs(cs8), .miso(miso8), .mosi(mosi), .finished(finished)
   );

   aes_serial_host #(.NK(4), .TIMEOUT(64)) u4 (
      .clk(clk), .rst(rst), .start(start4), .data_in(dataIn4), .key_in(keyIn4),
      .busy(busy4), .done(done4), .err(err4), .data_out(dataOut4),
      .cs(cs4), .miso(miso4), .mosi(mosi), .finished(finished)
   );

   logic coreCs, coreMiso, coreDone;
   assign coreCs   = sel ? cs4   : cs8;
   assign coreMiso = sel ? miso4 : miso8;
   assign coreDone = sel ? done4 : done8;

   typedef struct {
      logic [383:0] stream;
      int           len;
      logic [127:0] result;
   } xferT;

   xferT         xferQ[$];
   logic [127:0] doneQ[$];

   int vectors     = 0;
   int miscompares = 0;

   bit holdOff  = 1'b0;
   bit dropXfer = 1'b0;
   bit glitch   = 1'b0;
   bit inRead   = 1'b0;

   localparam logic [127:0] D1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] K8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] R8 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] K4 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] R4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] D2 = 128'hfedcba98765432100123456789abcdef;
   localparam logic [255:0] K2 = 256'h0f1e2d3c4b5a69788796a5b4c3d2e1f00123456789abcdeffedcba9876543210;
   localparam logic [127:0] R2 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] R3 = 128'hcafef00d0badc0de5555aaaa12345678;
   localparam logic [127:0] D4 = 128'h80000000000000000000000000000001;
   localparam logic [255:0] K5 = 256'hffffffffffffffff0000000000000000aaaaaaaaaaaaaaaa5555555555555555;
   localparam logic [127:0] R5 = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] R6 = 128'hffffffff00000000ffffffff00000001;

   // One comparison: counts it and reports a FAIL line on mismatch.
   task automatic checkOutput(input string name, input logic [383:0] actual,
                              input logic [383:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: actual %h, required %h", name, actual, expected);
      end
   endtask

   // Queues the expectation, pulses start on the selected host, scrambles
   // the parallel inputs after capture and checks the SETUP cycle.
   task automatic applyStimulus(input bit useNk4, input logic [127:0] d,
                                input logic [255:0] k, input logic [127:0] res,
                                input bit expectDone);
      xferT x;
      x.stream = useNk4 ? {128'h0, k[127:0], d} : {k, d};
      x.len    = useNk4 ? 256 : 384;
      x.result = res;
      xferQ.push_back(x);
      if (expectDone) doneQ.push_back(res);
      sel = useNk4;
      if (useNk4) begin
         dataIn4 = d;
         keyIn4  = k[127:0];
         start4  = 1'b1;
      end else begin
         dataIn8 = d;
         keyIn8  = k;
         start8  = 1'b1;
      end
      @(negedge clk);
      start4  = 1'b0;
      start8  = 1'b0;
      dataIn4 = ~dataIn4;
      keyIn4  = ~keyIn4;
      dataIn8 = ~dataIn8;
      keyIn8  = ~keyIn8;
      if (useNk4) checkOutput("setupCycle", 384'({busy4, cs4, miso4}), 384'(3'b110));
      else        checkOutput("setupCycle", 384'({busy8, cs8, miso8}), 384'(3'b110));
   endtask

   // Waits, bounded, until the selected host shows done.
   task automatic waitDone(input int limit);
      int n = 0;
      while (!coreDone && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (!coreDone) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL doneTimeout: actual no done after %0d cycles, required done", limit);
      end
   endtask

   // Behavioural core: captures the load stream, pulses finished after a
   // short delay and drives the result back LSB-first.
   initial begin : coreModel
      xferT         x;
      logic [383:0] cap;
      bit           aborted;
      mosi     = 1'b0;
      finished = 1'b0;
      forever begin
         @(negedge clk);
         if (rst && coreCs && xferQ.size() > 0) begin
            x       = xferQ.pop_front();
            cap     = '0;
            aborted = 1'b0;
            for (int i = 0; i < x.len && !aborted; i++) begin
               @(negedge clk);
               if (!rst) aborted = 1'b1;
               else begin
                  cap[i] = coreMiso;
                  if (glitch && i == 50) finished = 1'b1;
                  if (glitch && i == 51) finished = 1'b0;
               end
            end
            if (!aborted) begin
               @(negedge clk);
               checkOutput("loadStream", cap, x.stream);
               checkOutput("csFallsAfterLoad", 384'(coreCs), 384'(0));
               while (holdOff && !dropXfer) @(negedge clk);
               if (dropXfer) aborted = 1'b1;
            end
            if (!aborted) begin
               repeat (3) @(negedge clk);
               finished = 1'b1;
               @(negedge clk);
               finished = 1'b0;
               mosi     = ~x.result[0];
               inRead   = 1'b1;
               for (int k = 0; k < 128; k++) begin
                  @(negedge clk);
                  mosi = x.result[k];
               end
               @(negedge clk);
               mosi   = 1'b0;
               inRead = 1'b0;
               checkOutput("doneAtW130", 384'(coreDone), 384'(1));
            end
         end
      end
   end

   // Scoreboard monitor: every done pops one expected result.
   initial begin : monitor
      logic [127:0] exp;
      forever begin
         @(negedge clk);
         if (done8 || done4) begin
            if (doneQ.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL unexpectedDone: actual done pulse, required none");
            end else begin
               exp = doneQ.pop_front();
               checkOutput("dataOut", 384'(done8 ? dataOut8 : dataOut4), 384'(exp));
            end
         end
      end
   end

   // Absolute time limit so the run always ends.
   initial begin : globalWatchdog
      #500000;
      $display("[TB] FAIL globalTimeout: actual simulation still running, required finish");
      $fatal(1, "[TB] global timeout");
   end

   initial begin : mainSequence
      int  n;
      int  bad;
      rst     = 1'b0;
      sel     = 1'b0;
      start8  = 1'b0;
      start4  = 1'b0;
      dataIn8 = '0;
      dataIn4 = '0;
      keyIn8  = '0;
      keyIn4  = '0;
      repeat (3) @(negedge clk);
      checkOutput("resetOut8", 384'({busy8, done8, err8, cs8, miso8, dataOut8}), 384'(0));
      checkOutput("resetOut4", 384'({busy4, done4, err4, cs4, miso4, dataOut4}), 384'(0));
      rst = 1'b1;
      @(negedge clk);

      $display("[TB] NK=8 transfer");
      applyStimulus(1'b0, D1, K8, R8, 1'b1);
      waitDone(700);
      @(negedge clk);
      checkOutput("busyLowAfterDone", 384'(busy8), 384'(0));

      $display("[TB] NK=4 transfer");
      applyStimulus(1'b1, D1, {128'h0, K4}, R4, 1'b1);
      waitDone(700);
      @(negedge clk);
      checkOutput("busyLowAfterDone4", 384'(busy4), 384'(0));

      $display("[TB] start during LOAD and READ, finished during LOAD");
      glitch = 1'b1;
      applyStimulus(1'b0, D2, K2, R8, 1'b1);
      repeat (100) @(negedge clk);
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      n = 0;
      while (!inRead && n < 700) begin
         @(negedge clk);
         n++;
      end
      repeat (20) @(negedge clk);
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      waitDone(300);
      glitch = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("noRestart", 384'({busy8, cs8}), 384'(0));

      $display("[TB] reset at LOAD bit 200");
      applyStimulus(1'b0, D2, K2, R3, 1'b0);
      repeat (201) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midLoadReset", 384'({cs8, busy8, miso8, done8, dataOut8}), 384'(0));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      applyStimulus(1'b0, D2, K2, R2, 1'b1);
      waitDone(700);

      $display("[TB] finished withheld");
      holdOff = 1'b1;
`ifdef AES_HOST_TIMEOUT_EN
      applyStimulus(1'b0, D4, K5, R3, 1'b0);
      repeat (448) @(negedge clk);
      checkOutput("beforeTimeout", 384'({busy8, err8}), 384'(2'b10));
      @(negedge clk);
      checkOutput("timeoutErr", 384'({busy8, err8, cs8, done8}), 384'(4'b0100));
      checkOutput("timeoutDataHeld", 384'(dataOut8), 384'(R2));
      @(negedge clk);
      checkOutput("errOneCycle", 384'(err8), 384'(0));
      dropXfer = 1'b1;
      repeat (3) @(negedge clk);
      dropXfer = 1'b0;
      holdOff  = 1'b0;
`else
      applyStimulus(1'b0, D4, K5, R3, 1'b1);
      repeat (385) @(negedge clk);
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         if (!(busy8 === 1'b1 && err8 === 1'b0)) bad++;
         @(negedge clk);
      end
      checkOutput("waitHoldsBusy", 384'(bad), 384'(0));
      holdOff = 1'b0;
      waitDone(300);
`endif
      @(negedge clk);

      $display("[TB] back-to-back");
      applyStimulus(1'b0, D1, K5, R5, 1'b1);
      waitDone(700);
      applyStimulus(1'b0, D4, K8, R6, 1'b1);
      waitDone(700);

      repeat (5) @(negedge clk);
      checkOutput("allDonesSeen", 384'(doneQ.size()), 384'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/aes_serial_host.md
# aes_serial_host

Host-side initiator for the bit-serial AES core interface used by the `Encrypt` and `Decrypt` cores. It accepts a 128-bit block and a key in parallel and shifts them into the core LSB-first under `cs`. It then releases `cs`, waits for the core's `finished`, re-asserts `cs` and shifts the 128-bit result back into a parallel register. One instance sits in front of each core, which lets system logic use the cores without bit-level sequencing.

## Interface
- `NK`, default 8: key length in 32-bit words; legal values 4, 6, 8. `KEY_W = 32*NK`.
- `TIMEOUT`, default 64: maximum `WAIT` cycles; used only with `AES_HOST_TIMEOUT_EN`.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  request pulse; accepted only in `IDLE`.
- `data_in`  in  128  block to send; captured on accepted `start`.
- `key_in`  in  KEY_W  key to send; captured on accepted `start`.
- `busy`  out  1  high in every state except `IDLE`.
- `done`  out  1  one-cycle pulse when `data_out` is updated.
- `err`  out  1  one-cycle pulse on timeout abort; constant 0 without the macro.
- `data_out`  out  128  last received result; held until the next `done`.
- `cs`  out  1  chip select to the core's `cs`.
- `miso`  out  1  serial data to the core's `miso`.
- `mosi`  in  1  serial data from the core's `mosi`.
- `finished`  in  1  core completion flag.

## Operation
- States and transitions: `IDLE` -> `SETUP` -> `LOAD` -> `WAIT` -> `TURN` -> `READ` -> `IDLE`. `WAIT` exits to `IDLE` on timeout.
- `IDLE`:
  - `cs`=0, `miso`=0.
  - When `start`=1, capture `{key_in, data_in}` into a (128+KEY_W)-bit shift register, clear the bit counter and go to `SETUP`.
- `SETUP`: one cycle; `cs`=1, `miso`=0.
- `LOAD`:
  - `cs`=1 for 128+KEY_W cycles.
  - `miso` = shift register bit 0, then shift right by one each cycle.
  - Bit order: `data_in[0]`…`data_in[127]`, then `key_in[0]`…`key_in[KEY_W-1]`.
- `WAIT`:
  - `cs`=0, `miso`=0.
  - Exit to `TURN` on the first cycle `finished`=1 is sampled.
  - `finished` is ignored in every other state.
- `TURN`: one cycle; `cs`=1. `mosi` is not sampled.
- `READ`:
  - `cs`=1 for 128 cycles.
  - On cycle k (0..127), `mosi` is written into result bit k (LSB first).
  - After bit 127: copy the result to `data_out`, pulse `done`, go to `IDLE`.
- `start` while `busy` is ignored; no queueing.
- Changes on `data_in`/`key_in` after capture have no effect.
- The bit counter is 9 bits wide and compared against 128+KEY_W-1 (LOAD) or 127 (READ). It never wraps.
- Reset (`rst`=0 at an edge), in any state including mid-`LOAD`/`READ`:
  - next state `IDLE`;
  - `cs`=0, `miso`=0, `busy`=0, `done`=0, `err`=0;
  - `data_out`=0, shift register and counter cleared.
- Reset overrides a simultaneous `start`.

## Timing
- `start` is accepted at edge E0. `SETUP` occupies cycle E1.
- `LOAD` occupies cycles E2..E(1+128+KEY_W).
- `cs` is high continuously from E1 through the last `LOAD` cycle (385 cycles for NK=8).
- `cs` falls on the first `WAIT` cycle.
- If `finished` is sampled high in `WAIT` cycle W, `TURN` is cycle W+1 and `READ` is cycles W+2..W+129.
- `done` is high in cycle W+130, in the same cycle `data_out` changes, and `busy` falls.
- Minimum turnaround: `start` can be accepted again on the cycle `done` is high.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- `AES_HOST_TIMEOUT_EN` defined:
  - An 8-bit watchdog counter is cleared on entry to `WAIT` and increments each `WAIT` cycle.
  - If it reaches `TIMEOUT` with `finished` never sampled high: pulse `err` for one cycle, go to `IDLE`, `cs`=0, `data_out` unchanged, no `done`.
- `AES_HOST_TIMEOUT_EN` undefined:
  - `WAIT` lasts indefinitely until `finished`.
  - `err` tied 0; no watchdog logic.

## Test plan
- NK=8, `data_in`=00112233445566778899aabbccddeeff, `key_in`=000102…1f, behavioural core model returns 8ea2b7ca516745bfeafc49904b496089 -> `miso` stream matches bit order over 384 `LOAD` cycles; `cs` high 385 cycles; `data_out`=8ea2b7ca516745bfeafc49904b496089, `done` one cycle at W+130.
- NK=4, `data_in`=00112233445566778899aabbccddeeff, `key_in`=000102…0f, model returns 69c4e0d86a7b0430d8cdb78070b4c55a -> 256 `LOAD` cycles; `data_out` equals the returned value.
- `start` pulsed during `LOAD` and during `READ`, with `finished` pulsed during `LOAD` -> no restart, stream unchanged, only one `done`.
- `rst`=0 at `LOAD` bit 200 -> next cycle `cs`=0, `busy`=0, `data_out`=0; a subsequent `start` gives a complete, correct transfer.
- With `AES_HOST_TIMEOUT_EN`, `TIMEOUT`=64, `finished` held 0 -> `err` pulses after 64 `WAIT` cycles, `busy` falls, `data_out` unchanged. Without the macro -> `busy` stays high for 1000 cycles, `err`=0.
- Back-to-back: second `start` in the `done` cycle with new vectors -> second `SETUP` on the next cycle; both results correct.
